// File: rtl/branch_resolve_unit_if.sv
// Branch resolve bus: fetch-side pushes, execute-side resolves, and the
// predictor update / flush results returned by the resolve unit.
interface branch_resolve_unit_if #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned CNT_W = 16
);

  // Fetch-side push of predicted branches
  logic             push_valid_inst1;
  logic [PC_W-1:0]  push_pc_inst1;
  logic             push_pred_inst1;
  logic             push_valid_inst2;
  logic [PC_W-1:0]  push_pc_inst2;
  logic             push_pred_inst2;
  logic             fifo_full;

  // Execute-side resolution
  logic             res_valid_inst1;
  logic             res_taken_inst1;
  logic [PC_W-1:0]  res_target_inst1;
  logic             res_valid_inst2;
  logic             res_taken_inst2;
  logic [PC_W-1:0]  res_target_inst2;

  // Predictor update port
  logic             Branch_inst1;
  logic [PC_W-1:0]  PC_inst1_E;
  logic             actual_outcome_inst1;
  logic             Branch_inst2;
  logic [PC_W-1:0]  PC_inst2_E;
  logic             actual_outcome_inst2;

  // Redirect, statistics and sticky errors
  logic             flush;
  logic [PC_W-1:0]  redirect_pc;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;
  logic             err_overflow;
  logic             err_underflow;

  // Pipeline side: drives pushes and resolves, observes results
  modport master (
    output push_valid_inst1, push_pc_inst1, push_pred_inst1,
    output push_valid_inst2, push_pc_inst2, push_pred_inst2,
    output res_valid_inst1, res_taken_inst1, res_target_inst1,
    output res_valid_inst2, res_taken_inst2, res_target_inst2,
    input  fifo_full,
    input  Branch_inst1, PC_inst1_E, actual_outcome_inst1,
    input  Branch_inst2, PC_inst2_E, actual_outcome_inst2,
    input  flush, redirect_pc, branch_count, mispredict_count,
    input  err_overflow, err_underflow
  );

  // Resolve unit side
  modport slave (
    input  push_valid_inst1, push_pc_inst1, push_pred_inst1,
    input  push_valid_inst2, push_pc_inst2, push_pred_inst2,
    input  res_valid_inst1, res_taken_inst1, res_target_inst1,
    input  res_valid_inst2, res_taken_inst2, res_target_inst2,
    output fifo_full,
    output Branch_inst1, PC_inst1_E, actual_outcome_inst1,
    output Branch_inst2, PC_inst2_E, actual_outcome_inst2,
    output flush, redirect_pc, branch_count, mispredict_count,
    output err_overflow, err_underflow
  );

endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: in-order FIFO of predictions for in-flight branches,
// compared against execute outcomes; drives predictor training and flushes.
module branch_resolve_unit #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input logic                clk,
  input logic                reset,
  branch_resolve_unit_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = PtrW + 1;

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [OccW-1:0] occ_t;

  // FIFO storage and bookkeeping
  logic [PC_W-1:0]  pc_mem_q   [DEPTH];
  logic             pred_mem_q [DEPTH];
  ptr_t             head_q;
  ptr_t             tail_q;
  occ_t             count_q;

  // Statistics and sticky errors
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] mis_cnt_q;
  logic             err_ovf_q;
  logic             err_unf_q;

  // Registered outputs
  logic             br1_q;
  logic [PC_W-1:0]  pc1_q;
  logic             out1_q;
  logic             br2_q;
  logic [PC_W-1:0]  pc2_q;
  logic             out2_q;
  logic             flush_q;
  logic [PC_W-1:0]  redirect_q;

  // Resolve decode
  logic             r1, r2;
  logic             taken1, taken2;
  logic [PC_W-1:0]  target1, target2;
  ptr_t             head1;
  logic             have1, have2;
  logic             e1, e2, mis1, mis2, unf;
  logic [PC_W-1:0]  cpc1, cpc2;
  logic             flush_d;

  // Push decode
  occ_t             free;
  logic             room1, room2;
  logic             acc1, acc2, ovf;
  occ_t             npop, npush;
  ptr_t             tail2;

  // Saturating counter sums
  logic [CNT_W:0]   bsum, msum;

  // Resolve compare, push acceptance and counter next-state
  always_comb begin
    // An inst2-only resolve behaves as an inst1 resolve with inst2's data
    r1      = bus.res_valid_inst1 | bus.res_valid_inst2;
    r2      = bus.res_valid_inst1 & bus.res_valid_inst2;
    taken1  = bus.res_valid_inst1 ? bus.res_taken_inst1  : bus.res_taken_inst2;
    target1 = bus.res_valid_inst1 ? bus.res_target_inst1 : bus.res_target_inst2;
    taken2  = bus.res_taken_inst2;
    target2 = bus.res_target_inst2;

    head1 = head_q + ptr_t'(1);
    have1 = (count_q != occ_t'(0));
    have2 = (count_q >= occ_t'(2));

    e1   = r1 & have1;
    mis1 = e1 & (pred_mem_q[head_q] ^ taken1);
    // inst2 sits on the wrong path once inst1 mispredicts
    e2   = r2 & ~mis1 & have2;
    mis2 = e2 & (pred_mem_q[head1] ^ taken2);
    unf  = (r1 & ~have1) | (r2 & ~mis1 & ~have2);

    cpc1 = taken1 ? target1 : pc_mem_q[head_q] + PC_W'(1);
    cpc2 = taken2 ? target2 : pc_mem_q[head1] + PC_W'(1);
    flush_d = mis1 | mis2;

    // Room is judged on start-of-cycle occupancy; same-cycle pops don't help
    free  = occ_t'(DEPTH) - count_q;
    room1 = (free >= occ_t'(1));
    room2 = bus.push_valid_inst1 ? (free >= occ_t'(2)) : (free >= occ_t'(1));
    acc1  = ~flush_d & bus.push_valid_inst1 & room1;
    acc2  = ~flush_d & bus.push_valid_inst2 & room2;
    ovf   = ~flush_d & ((bus.push_valid_inst1 & ~room1) | (bus.push_valid_inst2 & ~room2));
    tail2 = acc1 ? tail_q + ptr_t'(1) : tail_q;

    npop  = occ_t'(e1) + occ_t'(e2);
    npush = occ_t'(acc1) + occ_t'(acc2);

    bsum = {1'b0, branch_cnt_q} + (CNT_W+1)'(e1) + (CNT_W+1)'(e2);
    msum = {1'b0, mis_cnt_q} + (CNT_W+1)'(mis1) + (CNT_W+1)'(mis2);
  end

  // FIFO, counters, sticky errors and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        pred_mem_q[i] <= 1'b0;
      end
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      branch_cnt_q <= '0;
      mis_cnt_q    <= '0;
      err_ovf_q    <= 1'b0;
      err_unf_q    <= 1'b0;
      br1_q        <= 1'b0;
      pc1_q        <= '0;
      out1_q       <= 1'b0;
      br2_q        <= 1'b0;
      pc2_q        <= '0;
      out2_q       <= 1'b0;
      flush_q      <= 1'b0;
      redirect_q   <= '0;
    end else begin
      if (acc1) begin
        pc_mem_q[tail_q]   <= bus.push_pc_inst1;
        pred_mem_q[tail_q] <= bus.push_pred_inst1;
      end
      if (acc2) begin
        pc_mem_q[tail2]   <= bus.push_pc_inst2;
        pred_mem_q[tail2] <= bus.push_pred_inst2;
      end

      if (flush_d) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        head_q  <= head_q + ptr_t'(npop);
        tail_q  <= tail_q + ptr_t'(npush);
        count_q <= count_q - npop + npush;
      end

      branch_cnt_q <= bsum[CNT_W] ? '1 : bsum[CNT_W-1:0];
      mis_cnt_q    <= msum[CNT_W] ? '1 : msum[CNT_W-1:0];
      err_ovf_q    <= err_ovf_q | ovf;
      err_unf_q    <= err_unf_q | unf;

      br1_q      <= e1;
      pc1_q      <= e1 ? pc_mem_q[head_q] : '0;
      out1_q     <= e1 & taken1;
      br2_q      <= e2;
      pc2_q      <= e2 ? pc_mem_q[head1] : '0;
      out2_q     <= e2 & taken2;
      flush_q    <= flush_d;
      redirect_q <= mis1 ? cpc1 : (mis2 ? cpc2 : '0);
    end
  end

  assign bus.fifo_full            = (count_q > occ_t'(DEPTH - 2));
  assign bus.Branch_inst1         = br1_q;
  assign bus.PC_inst1_E           = pc1_q;
  assign bus.actual_outcome_inst1 = out1_q;
  assign bus.Branch_inst2         = br2_q;
  assign bus.PC_inst2_E           = pc2_q;
  assign bus.actual_outcome_inst2 = out2_q;
  assign bus.flush                = flush_q;
  assign bus.redirect_pc          = redirect_q;
  assign bus.branch_count         = branch_cnt_q;
  assign bus.mispredict_count     = mis_cnt_q;
  assign bus.err_overflow         = err_ovf_q;
  assign bus.err_underflow        = err_unf_q;

endmodule
